// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus bit levels and address rules.
// Imported by the target responder and by the master driver.
package i2c_pkg;

  localparam int I2C_ADDR_W    = 7;
  localparam int I2C_BYTE_W    = 8;
  localparam int I2C_BIT_CNT_W = 4;

  // Bit counter values: last data clock of a byte and the ACK clock.
  localparam logic [I2C_BIT_CNT_W-1:0] I2C_BIT_DATA_LAST = 4'd7;
  localparam logic [I2C_BIT_CNT_W-1:0] I2C_BIT_ACK       = 4'd8;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;

  // SDA level after the edge (with SCL high) that marks START or STOP.
  localparam logic I2C_START_SDA = 1'b0;
  localparam logic I2C_STOP_SDA  = 1'b1;

  localparam logic [I2C_ADDR_W-1:0] I2C_GENERAL_CALL   = 7'h00;
  localparam logic [4:0]            I2C_TEN_BIT_PREFIX = 5'b11110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  // General call and 10-bit address headers are never claimed.
  function automatic logic i2c_addr_accept(
    input logic [I2C_ADDR_W-1:0] addr,
    input logic [I2C_ADDR_W-1:0] own
  );
    return (addr == own) &&
           (addr != I2C_GENERAL_CALL) &&
           (addr[I2C_ADDR_W-1:2] != I2C_TEN_BIT_PREFIX);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: synchroniser, run-length glitch filter and edge pulses.
// The edge pulses are coincident with the change of o_level.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses <= so every flop sees pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
    end
  end

  // The level flips only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sample == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
        r_level <= w_sample;
        r_cnt   <= '0;
        r_rise  <= w_sample;
        r_fall  <= ~w_sample;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target.sv
// I2C target responder: START/STOP detection, 7-bit address match, write bytes
// out on a valid strobe, read bytes fetched over a tx_req/tx_data handshake.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h3C,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    FILT_LEN    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  I2C_SCL,
  inout  wire                   I2C_SDA,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_req,
  output logic                  addr_match,
  output logic                  rw,
  output logic                  busy
);

  localparam logic SDA_RELEASE = 1'b1;

  logic w_scl_f, w_scl_rise, w_scl_fall;
  logic w_sda_f, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_scl_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (I2C_SCL),
    .o_level(w_scl_f),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sda_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_line (I2C_SDA),
    .o_level(w_sda_f),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  assign w_start = w_scl_f && (w_sda_rise || w_sda_fall) && (w_sda_f == I2C_START_SDA);
  assign w_stop  = w_scl_f && (w_sda_rise || w_sda_fall) && (w_sda_f == I2C_STOP_SDA);

  i2c_tgt_state_t             r_state;
  logic [I2C_BIT_CNT_W-1:0]   r_bit_cnt;
  logic [I2C_BYTE_W-1:0]      r_shift;
  logic                       r_sda_out;
  logic [I2C_BYTE_W-1:0]      r_rx_data;
  logic                       r_rx_valid;
  logic                       r_tx_req;
  logic                       r_addr_match;
  logic                       r_rw;
  logic                       r_busy;

  // Open drain: only ever pull low or let go.
  assign I2C_SDA = (r_sda_out == SDA_RELEASE) ? 1'bz : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_sda_out    <= SDA_RELEASE;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_tx_req     <= 1'b0;
      r_addr_match <= 1'b0;
      r_rw         <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // NOTE: strobes default low here; a later assignment in this block wins.
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;

      if (r_tx_req) begin
        r_shift <= tx_data;
      end

      if (w_scl_rise) begin
        r_bit_cnt <= (r_bit_cnt == I2C_BIT_ACK) ? '0 : r_bit_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_sda_out <= SDA_RELEASE;
        end

        ST_ADDR: begin
          if (w_scl_rise) begin
            r_shift <= {r_shift[I2C_BYTE_W-2:0], w_sda_f};
            if (r_bit_cnt == I2C_BIT_DATA_LAST) begin
              if (i2c_addr_accept(r_shift[I2C_ADDR_W-1:0], TARGET_ADDR)) begin
                r_rw    <= w_sda_f;
                r_state <= ST_ADDR_ACK;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
        end

        // Entry fall (counter at the ACK clock) starts the ACK; the 9th fall ends it.
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == I2C_BIT_ACK) begin
              r_sda_out    <= I2C_ACK;
              r_addr_match <= 1'b1;
              r_tx_req     <= (r_rw == I2C_RW_READ);
            end else if (r_rw == I2C_RW_WRITE) begin
              r_sda_out <= SDA_RELEASE;
              r_state   <= ST_WRITE;
            end else begin
              r_sda_out <= r_shift[I2C_BYTE_W-1];
              r_state   <= ST_READ;
            end
          end
        end

        ST_WRITE: begin
          if (w_scl_rise) begin
            r_shift <= {r_shift[I2C_BYTE_W-2:0], w_sda_f};
            if (r_bit_cnt == I2C_BIT_DATA_LAST) begin
              r_rx_data  <= {r_shift[I2C_BYTE_W-2:0], w_sda_f};
              r_rx_valid <= 1'b1;
              r_state    <= ST_WRITE_ACK;
            end
          end
        end

        ST_WRITE_ACK: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == I2C_BIT_ACK) begin
              r_sda_out <= I2C_ACK;
            end else begin
              r_sda_out <= SDA_RELEASE;
              r_state   <= ST_WRITE;
            end
          end
        end

        ST_READ: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == I2C_BIT_ACK) begin
              r_sda_out <= SDA_RELEASE;
              r_state   <= ST_READ_ACK;
            end else begin
              r_shift   <= {r_shift[I2C_BYTE_W-2:0], 1'b0};
              r_sda_out <= r_shift[I2C_BYTE_W-2];
            end
          end
        end

        ST_READ_ACK: begin
          r_sda_out <= SDA_RELEASE;
          if (w_scl_rise) begin
            if (w_sda_f == I2C_NACK) begin
              r_state <= ST_IGNORE;
            end else begin
              r_tx_req <= 1'b1;
            end
          end else if (w_scl_fall && (r_bit_cnt == '0)) begin
            r_sda_out <= r_shift[I2C_BYTE_W-1];
            r_state   <= ST_READ;
          end
        end

        ST_IGNORE: begin
          r_sda_out <= SDA_RELEASE;
        end

        default: begin
          r_sda_out <= SDA_RELEASE;
          r_state   <= ST_IDLE;
        end
      endcase

      // Bus conditions override whatever the state machine decided above.
      if (w_start) begin
        r_state      <= ST_ADDR;
        r_bit_cnt    <= '0;
        r_sda_out    <= SDA_RELEASE;
        r_tx_req     <= 1'b0;
        r_addr_match <= 1'b0;
        r_busy       <= 1'b1;
      end else if (w_stop) begin
        r_state      <= ST_IDLE;
        r_bit_cnt    <= '0;
        r_sda_out    <= SDA_RELEASE;
        r_tx_req     <= 1'b0;
        r_addr_match <= 1'b0;
        r_busy       <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign tx_req     = r_tx_req;
  assign addr_match = r_addr_match;
  assign rw         = r_rw;
  assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C master plus a transaction-level
// reference model (address rule, byte queues, request count).
module tb_i2c_target;

  localparam int         Q   = 12;
  localparam logic [6:0] OWN = 7'h3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       m_scl;
  logic       m_sda_low;
  wire        sda_bus;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_match, rw, busy;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_target #(
    .TARGET_ADDR(OWN),
    .SYNC_STAGES(2),
    .FILT_LEN   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .I2C_SCL   (m_scl),
    .I2C_SDA   (sda_bus),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_req    (tx_req),
    .addr_match(addr_match),
    .rw        (rw),
    .busy      (busy)
  );

  // Read data source: byte n of the run answers the n-th request.
  logic [7:0] tx_mem [256];
  int         tx_idx = 0;
  bit         tx_adv = 1'b0;
  assign tx_data = tx_mem[tx_idx[7:0]];

  int         rx_cnt = 0;
  int         tx_req_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  always @(negedge clk) begin
    if (tx_adv) tx_idx = tx_idx + 1;
    tx_adv = tx_req;
    if (tx_req) tx_req_cnt = tx_req_cnt + 1;
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = rx_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL clock: SDA set mid-low, optional 1-clk SDA glitch mid-high, sample late high.
  task automatic send_bit(input bit b, input bit glitch, output bit smp);
    m_sda_low = ~b;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q / 2);
    if (glitch) begin
      m_sda_low = ~m_sda_low;
      wait_clk(1);
      m_sda_low = ~m_sda_low;
    end
    wait_clk(Q / 2);
    smp = sda_bus;
    wait_clk(Q / 2);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(Q);
    m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q);
    m_sda_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  // Returns acked = 1 when the target pulled SDA low on the 9th clock.
  task automatic write_byte(input logic [7:0] b, input bit glitch, output bit acked);
    bit s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch, s);
    send_bit(1'b1, 1'b0, s);
    acked = ~s;
  endtask

  task automatic read_byte(input bit m_ack, output logic [7:0] d);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    send_bit(~m_ack, 1'b0, s);
  endtask

  function automatic bit model_accept(input logic [6:0] a);
    return (a == OWN) && (a != 7'h00) && (a[6:2] != 5'b11110);
  endfunction

  bit         ack;
  logic [7:0] d;
  int         rx0;
  int         exp_tx = 0;

  initial begin
    for (int i = 0; i < 256; i++) tx_mem[i] = 8'($urandom);
    m_scl     = 1'b1;
    m_sda_low = 1'b0;
    rst_n     = 1'b0;
    wait_clk(5);
    check("reset_sda_released", sda_bus, 1'b1);
    check("reset_outputs", {rx_data, rx_valid, tx_req, addr_match, rw, busy}, 13'h0);
    rst_n = 1'b1;
    wait_clk(10);

    // Write 0xA5 to own address.
    rx0 = rx_cnt;
    i2c_start();
    check("wr_busy_after_start", busy, 1'b1);
    write_byte({OWN, 1'b0}, 1'b0, ack);
    check("wr_addr_ack", ack, 1'b1);
    check("wr_addr_match", addr_match, 1'b1);
    check("wr_rw", rw, 1'b0);
    write_byte(8'hA5, 1'b0, ack);
    check("wr_data_ack", ack, 1'b1);
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_rx_valid_count", rx_cnt - rx0, 1);
    check("wr_match_before_stop", {addr_match, rw}, 2'b10);
    i2c_stop();
    check("wr_busy_after_stop", busy, 1'b0);
    check("wr_match_after_stop", addr_match, 1'b0);

    // Write to a foreign address.
    rx0 = rx_cnt;
    i2c_start();
    write_byte({7'h3D, 1'b0}, 1'b0, ack);
    check("miss_no_ack", ack, 1'b0);
    check("miss_addr_match", addr_match, 1'b0);
    check("miss_busy", busy, 1'b1);
    check("miss_no_rx", rx_cnt - rx0, 0);
    i2c_stop();
    check("miss_busy_after_stop", busy, 1'b0);

    // Read two bytes: ACK then NACK.
    tx_mem[exp_tx[7:0]]       = 8'h5A;
    tx_mem[exp_tx[7:0] + 8'd1] = 8'hC3;
    i2c_start();
    write_byte({OWN, 1'b1}, 1'b0, ack);
    check("rd_addr_ack", ack, 1'b1);
    check("rd_rw", rw, 1'b1);
    read_byte(1'b1, d);
    check("rd_byte0", d, 8'h5A);
    read_byte(1'b0, d);
    check("rd_byte1", d, 8'hC3);
    exp_tx += 2;
    check("rd_tx_req_count", tx_req_cnt, exp_tx);
    check("rd_sda_released", sda_bus, 1'b1);
    i2c_stop();
    check("rd_busy_after_stop", busy, 1'b0);

    // Write, repeated START, read.
    i2c_start();
    write_byte({OWN, 1'b0}, 1'b0, ack);
    write_byte(8'h11, 1'b0, ack);
    check("rs_rx_data", rx_data, 8'h11);
    check("rs_rw_write", rw, 1'b0);
    i2c_start();
    check("rs_match_cleared", addr_match, 1'b0);
    check("rs_busy", busy, 1'b1);
    write_byte({OWN, 1'b1}, 1'b0, ack);
    check("rs_addr_ack", ack, 1'b1);
    check("rs_match_set", addr_match, 1'b1);
    check("rs_rw_read", rw, 1'b1);
    read_byte(1'b0, d);
    check("rs_read_byte", d, tx_mem[exp_tx[7:0]]);
    exp_tx += 1;
    i2c_stop();
    check("rs_tx_req_count", tx_req_cnt, exp_tx);

    // Glitches: on an idle bus, then on every data bit of a write.
    m_sda_low = 1'b1;
    wait_clk(1);
    m_sda_low = 1'b0;
    wait_clk(20);
    check("glitch_idle_busy", busy, 1'b0);
    rx0 = rx_cnt;
    i2c_start();
    write_byte({OWN, 1'b0}, 1'b0, ack);
    write_byte(8'h5C, 1'b1, ack);
    check("glitch_data_ack", ack, 1'b1);
    check("glitch_rx_last", rx_last, 8'h5C);
    check("glitch_rx_count", rx_cnt - rx0, 1);
    check("glitch_still_busy", {busy, addr_match}, 2'b11);
    i2c_stop();

    // Randomised transactions against the model.
    for (int t = 0; t < 10; t++) begin
      logic [6:0] a;
      bit         r;
      bit         hit;
      int         len;
      logic [7:0] b;
      a   = ($urandom_range(0, 2) == 0) ? 7'($urandom) : OWN;
      r   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 3);
      hit = model_accept(a);
      rx0 = rx_cnt;
      i2c_start();
      write_byte({a, r}, 1'b0, ack);
      check($sformatf("rnd%0d_addr_ack", t), ack, hit);
      check($sformatf("rnd%0d_addr_match", t), addr_match, hit);
      if (hit && !r) begin
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          write_byte(b, 1'b0, ack);
          check($sformatf("rnd%0d_wr_ack%0d", t, k), ack, 1'b1);
          check($sformatf("rnd%0d_wr_data%0d", t, k), rx_data, b);
        end
        check($sformatf("rnd%0d_rx_count", t), rx_cnt - rx0, len);
      end else if (hit && r) begin
        for (int k = 0; k < len; k++) begin
          read_byte(k < len - 1, d);
          check($sformatf("rnd%0d_rd_data%0d", t, k), d, tx_mem[exp_tx[7:0] + 8'(k)]);
        end
        exp_tx += len;
        check($sformatf("rnd%0d_tx_req_count", t), tx_req_cnt, exp_tx);
      end else begin
        check($sformatf("rnd%0d_busy_unmatched", t), busy, 1'b1);
      end
      i2c_stop();
      check($sformatf("rnd%0d_idle_after_stop", t), {busy, addr_match}, 2'b00);
    end

    // Reset asserted while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      bit s;
      send_bit(i == 0 ? 1'b0 : OWN[i - 1], 1'b0, s);
    end
    m_sda_low = 1'b0;
    wait_clk(Q);
    m_scl = 1'b1;
    wait_clk(Q / 2);
    check("rst_ack_driven", sda_bus, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_sda_released", sda_bus, 1'b1);
    check("rst_outputs", {rx_data, rx_valid, tx_req, addr_match, rw, busy}, 13'h0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);
    rx0 = rx_cnt;
    i2c_start();
    write_byte({OWN, 1'b0}, 1'b0, ack);
    check("post_rst_addr_ack", ack, 1'b1);
    write_byte(8'h3E, 1'b0, ack);
    check("post_rst_rx_data", rx_data, 8'h3E);
    check("post_rst_rx_count", rx_cnt - rx0, 1);
    i2c_stop();
    check("post_rst_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
